// File: rtl/id_stream_gen.sv
// Identifier stream generator: emits letters, digits and a space separator over a
// valid/ready handshake, with a per-character prediction of the detector's output.
module id_stream_gen #(
    parameter int LEN_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [LEN_W-1:0] n_alpha,
    input  logic [LEN_W-1:0] n_digit,
    input  logic             upper,
    output logic [7:0]       char,
    output logic             char_valid,
    input  logic             char_ready,
    output logic             match,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {IDLE, ALPHA, DIGIT, SEP} state_t;

    localparam logic [LEN_W-1:0] ONE = LEN_W'(1);

    state_t           state, state_nxt;
    logic [LEN_W-1:0] na_q, nd_q, cnt;
    logic             up_q;
    logic [4:0]       letter_idx;
    logic [3:0]       digit_idx;
    logic [7:0]       char_cur, char_last;
    logic             xfer, cnt_last;

    function automatic logic [7:0] glyph(input state_t s, input logic up,
                                         input logic [4:0] li, input logic [3:0] di);
        case (s)
            ALPHA:   glyph = (up ? 8'h41 : 8'h61) + {3'b000, li};
            DIGIT:   glyph = 8'h30 + {4'b0000, di};
            default: glyph = 8'h20;
        endcase
    endfunction

    assign char_cur = glyph(state, up_q, letter_idx, digit_idx);
    assign xfer     = char_valid && char_ready;
    // cnt counts transfers within the current run; comparing against n-1 keeps it below 2^LEN_W-1
    assign cnt_last = (state == ALPHA) ? (cnt == na_q - ONE) : (cnt == nd_q - ONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            letter_idx <= '0;
            digit_idx  <= '0;
            char_last  <= 8'h00;
            done       <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= (state == SEP) && xfer;
            if (state != IDLE)
                char_last <= char_cur;
            case (state)
                IDLE: if (start) begin
                    na_q       <= n_alpha;
                    nd_q       <= n_digit;
                    up_q       <= upper;
                    cnt        <= '0;
                    letter_idx <= '0;
                    digit_idx  <= '0;
                end
                ALPHA: if (xfer) begin
                    letter_idx <= (letter_idx == 5'd25) ? 5'd0 : letter_idx + 5'd1;
                    cnt        <= cnt_last ? '0 : cnt + ONE;
                end
                DIGIT: if (xfer) begin
                    digit_idx <= (digit_idx == 4'd9) ? 4'd0 : digit_idx + 4'd1;
                    cnt       <= cnt_last ? '0 : cnt + ONE;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) begin
                if (n_alpha != '0)      state_nxt = ALPHA;
                else if (n_digit != '0) state_nxt = DIGIT;
                else                    state_nxt = SEP;
            end
            ALPHA: if (xfer && cnt_last)
                state_nxt = (nd_q != '0) ? DIGIT : SEP;
            DIGIT: if (xfer && cnt_last)
                state_nxt = SEP;
            SEP: if (xfer)
                state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // In IDLE the last emitted character stays on char
    always_comb begin
        char_valid = (state != IDLE);
        busy       = (state != IDLE);
        match      = (state == DIGIT) && (na_q != '0);
        char       = (state == IDLE) ? char_last : char_cur;
    end

endmodule
